// File: rtl/gelato_types.sv
// gelato_types: shared ALU opcodes, FSM states and compute-unit sizing.
package gelato_types;

    localparam int THREAD_NUM = 32;
    localparam int XLEN       = 32;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RELEASE
    } alu_state_t;

endpackage

// File: rtl/gelato_compute_task_if.sv
// gelato_compute_task_if: scheduler-to-ALU task handshake carrying warp-wide operands and results.
interface gelato_compute_task_if;
    import gelato_types::*;

    logic                             valid;
    alu_op_t                          op;
    logic [THREAD_NUM-1:0][XLEN-1:0]  rs1;
    logic [THREAD_NUM-1:0][XLEN-1:0]  rs2;
    logic [THREAD_NUM-1:0][XLEN-1:0]  rd;
    logic                             done;

    modport master (output valid, op, rs1, rs2, input rd, done);
    modport slave  (input valid, op, rs1, rs2, output rd, done);

endinterface

// File: rtl/gelato_alu_lane.sv
// gelato_alu_lane: combinational single-thread 32-bit integer ALU.
module gelato_alu_lane
    import gelato_types::*;
(
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [XLEN-1:0] sra;

    // Kept out of the ternary chain so the shift stays in a signed context.
    assign sra = $signed(a) >>> b[4:0];

    always_comb begin
        y = op == ALU_ADD  ? a + b :
            op == ALU_SUB  ? a - b :
            op == ALU_AND  ? a & b :
            op == ALU_OR   ? a | b :
            op == ALU_XOR  ? a ^ b :
            op == ALU_SLL  ? a << b[4:0] :
            op == ALU_SRL  ? a >> b[4:0] :
            op == ALU_SRA  ? sra :
            op == ALU_SLT  ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
            op == ALU_SLTU ? {{(XLEN-1){1'b0}}, a < b} :
                             '0;
    end

endmodule

// File: rtl/gelato_compute_alu_array.sv
// gelato_compute_alu_array: batched lane-parallel ALU running one warp-wide task per handshake.
module gelato_compute_alu_array
    import gelato_types::*;
#(
    parameter int LANES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    gelato_compute_task_if.slave compute_task
);

    localparam int NB = THREAD_NUM / LANES;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    if (THREAD_NUM % LANES != 0) begin : g_bad_lanes
        $error("THREAD_NUM must be a multiple of LANES");
    end

    alu_state_t                            state;
    alu_state_t                            state_d;
    logic [CW-1:0]                         cnt;
    logic                                  last;
    logic                                  done_q;
    alu_op_t                               op_q;
    logic [NB-1:0][LANES-1:0][XLEN-1:0]    a_q;
    logic [NB-1:0][LANES-1:0][XLEN-1:0]    b_q;
    logic [NB-1:0][LANES-1:0][XLEN-1:0]    rd_q;
    logic [LANES-1:0][XLEN-1:0]            lane_y;

    assign last              = cnt == CW'(NB - 1);
    assign compute_task.rd   = rd_q;
    assign compute_task.done = done_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gelato_alu_lane u_lane (
            .op (op_q),
            .a  (a_q[cnt][l]),
            .b  (b_q[cnt][l]),
            .y  (lane_y[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else if (rdy)
            state <= state_d;
    end

    // The last batch wins over a dropped valid so a completing task always pulses done.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:    state_d = compute_task.valid ? ST_EXEC : ST_IDLE;
            ST_EXEC:    state_d = last ? ST_RELEASE : compute_task.valid ? ST_EXEC : ST_IDLE;
            ST_RELEASE: state_d = compute_task.valid ? ST_RELEASE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            done_q <= 1'b0;
            op_q   <= ALU_ADD;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
        end else if (rdy) begin
            done_q <= state == ST_EXEC && last;
            if (state == ST_IDLE && compute_task.valid) begin
                op_q <= compute_task.op;
                a_q  <= compute_task.rs1;
                b_q  <= compute_task.rs2;
                cnt  <= '0;
            end
            if (state == ST_EXEC) begin
                rd_q[cnt] <= lane_y;
                cnt       <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gelato_compute_alu_array.sv
// tb_gelato_compute_alu_array: directed and randomized checks against a task-level reference model.
module tb_gelato_compute_alu_array;
    import gelato_types::*;

    localparam int LANES = 8;
    localparam int NB    = THREAD_NUM / LANES;

    typedef logic [THREAD_NUM-1:0][31:0] vec_t;

    logic clk;
    logic rst_n;
    logic rdy;
    logic chk_en;
    int   nvec;
    int   nerr;

    gelato_compute_task_if tif ();

    gelato_compute_alu_array #(.LANES(LANES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .compute_task (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        int signed sa = a;
        int signed sb = b;
        int unsigned sh = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic vec_t with_batch(input vec_t cur, input alu_op_t op, input vec_t a, input vec_t b, input int k);
        vec_t r = cur;
        for (int j = 0; j < LANES; j++)
            r[k*LANES+j] = ref_alu(op, a[k*LANES+j], b[k*LANES+j]);
        return r;
    endfunction

    // Task-level reference: accept, NB batch steps, one done pulse, wait for valid to fall.
    vec_t    m_a, m_b, exp_rd;
    alu_op_t m_op;
    int      m_phase, m_k;
    logic    exp_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_k      <= 0;
            exp_rd   <= '0;
            exp_done <= 1'b0;
        end else if (rdy) begin
            exp_done <= 1'b0;
            if (m_phase == 0 && tif.valid) begin
                m_op    <= tif.op;
                m_a     <= tif.rs1;
                m_b     <= tif.rs2;
                m_k     <= 0;
                m_phase <= 1;
            end else if (m_phase == 1) begin
                exp_rd <= with_batch(exp_rd, m_op, m_a, m_b, m_k);
                m_k    <= m_k + 1;
                if (m_k == NB - 1) begin
                    exp_done <= 1'b1;
                    m_phase  <= 2;
                end else if (!tif.valid) begin
                    m_phase <= 0;
                end
            end else if (m_phase == 2 && !tif.valid) begin
                m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            nvec++;
            if (tif.done !== exp_done) begin
                nerr++;
                $display("FAIL done @%0t: got %0b expected %0b", $time, tif.done, exp_done);
            end
            nvec++;
            if (tif.rd !== exp_rd) begin
                nerr++;
                for (int i = 0; i < THREAD_NUM; i++)
                    if (tif.rd[i] !== exp_rd[i]) begin
                        $display("FAIL rd[%0d] @%0t: got 0x%08h expected 0x%08h", i, $time, tif.rd[i], exp_rd[i]);
                        break;
                    end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_task(input string name, input alu_op_t op, input vec_t a, input vec_t b,
                            input int stall_len, input int hold, output int lat);
        int extra;
        tif.op    = op;
        tif.rs1   = a;
        tif.rs2   = b;
        tif.valid = 1'b1;
        rdy       = 1'b1;
        lat       = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (tif.done) begin
                lat = c;
                break;
            end
            rdy = !(c >= 2 && c < 2 + stall_len);
        end
        rdy   = 1'b1;
        extra = 0;
        repeat (hold) begin
            @(negedge clk);
            extra += int'(tif.done);
        end
        tif.valid = 1'b0;
        @(negedge clk);
        extra += int'(tif.done);
        chk({name, "_done_once"}, extra, 0);
    endtask

    function automatic vec_t fill(input logic [31:0] v);
        vec_t r;
        for (int i = 0; i < THREAD_NUM; i++) r[i] = v;
        return r;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic vec_t rnd_vec();
        vec_t r;
        for (int i = 0; i < THREAD_NUM; i++) r[i] = rnd_word();
        return r;
    endfunction

    initial begin
        vec_t a, b, rd_add;
        int   lat, pulses;
        nvec      = 0;
        nerr      = 0;
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        rdy       = 1'b1;
        tif.valid = 1'b0;
        tif.op    = ALU_ADD;
        tif.rs1   = '0;
        tif.rs2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_rd", 32'(|tif.rd), 0);
        chk("reset_done", 32'(tif.done), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < THREAD_NUM; i++) begin
            a[i] = 32'(i);
            b[i] = 32'd5;
        end
        run_task("add", ALU_ADD, a, b, 0, 0, lat);
        chk("add_latency", lat, NB + 1);
        for (int i = 0; i < THREAD_NUM; i++) chk("add_lane", tif.rd[i], 32'(i + 5));
        rd_add = tif.rd;
        repeat (3) @(negedge clk);
        chk("add_hold", 32'(tif.rd == rd_add), 1);

        run_task("wrap_add", ALU_ADD, fill(32'hFFFFFFFF), fill(32'd1), 0, 0, lat);
        chk("wrap_add", tif.rd[0], 32'h0);
        run_task("wrap_sub", ALU_SUB, fill(32'h0), fill(32'd1), 0, 0, lat);
        chk("wrap_sub", tif.rd[31], 32'hFFFFFFFF);
        run_task("slt", ALU_SLT, fill(32'hFFFFFFFF), fill(32'd1), 0, 0, lat);
        chk("slt", tif.rd[7], 32'd1);
        run_task("sltu", ALU_SLTU, fill(32'hFFFFFFFF), fill(32'd1), 0, 0, lat);
        chk("sltu", tif.rd[8], 32'd0);
        run_task("sra", ALU_SRA, fill(32'h80000000), fill(32'd4), 0, 0, lat);
        chk("sra", tif.rd[16], 32'hF8000000);
        run_task("srl", ALU_SRL, fill(32'h80000000), fill(32'd4), 0, 0, lat);
        chk("srl", tif.rd[24], 32'h08000000);
        run_task("sll", ALU_SLL, fill(32'h80000000), fill(32'd36), 0, 0, lat);
        chk("sll", tif.rd[31], 32'h0);
        run_task("undef", alu_op_t'(4'd13), fill(32'h1234), fill(32'h55), 0, 0, lat);
        chk("undef_zero", 32'(|tif.rd), 0);

        run_task("stall", ALU_ADD, a, b, 3, 0, lat);
        chk("stall_latency", lat, NB + 4);
        chk("stall_rd_equal", 32'(tif.rd == rd_add), 1);

        run_task("hold", ALU_XOR, fill(32'hF0F0F0F0), fill(32'h0FF00FF0), 0, 3, lat);
        chk("hold_latency", lat, NB + 1);
        chk("hold_xor", tif.rd[3], 32'hFF00FF00);

        for (int i = 0; i < THREAD_NUM; i++) begin
            a[i] = 32'(100 + i);
            b[i] = 32'd1;
        end
        tif.op    = ALU_ADD;
        tif.rs1   = a;
        tif.rs2   = b;
        tif.valid = 1'b1;
        pulses    = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(tif.done);
        end
        tif.valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(tif.done);
        end
        chk("abort_no_done", pulses, 0);
        chk("abort_slice0", tif.rd[0], 32'd101);
        run_task("after_abort", ALU_SUB, a, b, 0, 0, lat);
        chk("after_abort_latency", lat, NB + 1);
        chk("after_abort_lane", tif.rd[30], 32'd129);

        tif.op    = ALU_OR;
        tif.rs1   = fill(32'hA5A50000);
        tif.rs2   = fill(32'h00005A5A);
        tif.valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_n     = 1'b0;
        tif.valid = 1'b0;
        #1;
        chk("midrst_rd", 32'(|tif.rd), 0);
        chk("midrst_done", 32'(tif.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_task("post_reset", ALU_OR, fill(32'hA5A50000), fill(32'h00005A5A), 0, 0, lat);
        chk("post_reset_latency", lat, NB + 1);
        chk("post_reset_or", tif.rd[12], 32'hA5A55A5A);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rdy = $urandom_range(0, 7) != 0;
            if (tif.valid) begin
                if (tif.done ? $urandom_range(0, 3) != 0 : $urandom_range(0, 40) == 0)
                    tif.valid = 1'b0;
                else if ($urandom_range(0, 9) == 0)
                    tif.rs1 = rnd_vec();
            end else if ($urandom_range(0, 2) == 0) begin
                tif.op    = alu_op_t'(4'($urandom_range(0, 11)));
                tif.rs1   = rnd_vec();
                tif.rs2   = rnd_vec();
                tif.valid = 1'b1;
            end
        end
        tif.valid = 1'b0;
        rdy       = 1'b1;
        repeat (NB + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
